// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous imem (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch front end: PC, synchronous imem request, IF/EX register and one-entry replay buffer.
// Optional stall-cycle counter is built only when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            flush_id_exec,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            inst_valid,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {
        REFILL = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic            hold_valid_q;
    logic [XLEN-1:0] hold_inst_q;
    logic [XLEN-1:0] hold_pc_q;
    logic            resp_valid_q;
    logic            unused_target_bits;

    // A response is in flight exactly when the previous cycle was an unhindered fetch.
    assign resp_valid_q = (state_q == RUN);

    assign imem.imem_req    = ~rst & ~branch_taken & ~stall_if;
    assign imem.imem_addr   = pc_q;
    assign unused_target_bits = ^branch_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REFILL;
            pc_q         <= RESET_PC;
            resp_pc_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= NOP_INST;
            hold_pc_q    <= '0;
            inst_out     <= NOP_INST;
            pc_out       <= '0;
            inst_valid   <= 1'b0;
        end else if (branch_taken) begin
            state_q      <= REFILL;
            pc_q         <= {branch_target[XLEN-1:2], 2'b00};
            hold_valid_q <= 1'b0;
            inst_out     <= NOP_INST;
            pc_out       <= '0;
            inst_valid   <= 1'b0;
        end else if (stall_if) begin
            // The arriving response is parked even if IF/EX is being flushed.
            state_q <= STALL;
            if (resp_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_inst_q  <= imem.imem_rdata;
                hold_pc_q    <= resp_pc_q;
            end
            inst_out   <= NOP_INST;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else begin
            state_q      <= RUN;
            pc_q         <= pc_q + XLEN'(4);
            resp_pc_q    <= pc_q;
            hold_valid_q <= 1'b0;
            if (flush_id_exec || !(hold_valid_q || resp_valid_q)) begin
                inst_out   <= NOP_INST;
                pc_out     <= '0;
                inst_valid <= 1'b0;
            end else if (hold_valid_q) begin
                inst_out   <= hold_inst_q;
                pc_out     <= hold_pc_q;
                inst_valid <= 1'b1;
            end else begin
                inst_out   <= imem.imem_rdata;
                pc_out     <= resp_pc_q;
                inst_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_if) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequences with literal expectations,
// then randomized hazards compared every cycle against an instruction-stream model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        flush_id_exec;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model: next fetch address, the fetch whose data arrives next edge,
    // and fetched-but-undelivered PCs (the replay buffer seen as a queue).
    logic [31:0] m_pc;
    logic        m_fl_v;
    logic [31:0] m_fl_pc;
    logic [31:0] ready_q[$];
    logic [31:0] m_inst;
    logic [31:0] m_pcout;
    logic        m_valid;
    logic [31:0] m_cnt;

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .flush_id_exec (flush_id_exec),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    // Synchronous imem: content is addr ^ KEY; garbage when no request was made.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ KEY) : $urandom();
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_bubble();
        m_inst  = NOP;
        m_pcout = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] p;
        if (rst) begin
            m_pc   = 32'h0;
            m_fl_v = 1'b0;
            ready_q.delete();
            m_cnt  = 32'h0;
            model_bubble();
        end else begin
`ifdef FETCH_STALL_CNT_EN
            if (stall_if) m_cnt = m_cnt + 32'd1;
`endif
            if (branch_taken) begin
                m_pc   = branch_target & 32'hFFFF_FFFC;
                m_fl_v = 1'b0;
                ready_q.delete();
                model_bubble();
            end else begin
                if (m_fl_v) ready_q.push_back(m_fl_pc);
                m_fl_v = 1'b0;
                if (stall_if) begin
                    model_bubble();
                end else begin
                    if (ready_q.size() > 0) begin
                        p = ready_q.pop_front();
                        if (flush_id_exec) begin
                            model_bubble();
                        end else begin
                            m_inst  = p ^ KEY;
                            m_pcout = p;
                            m_valid = 1'b1;
                        end
                    end else begin
                        model_bubble();
                    end
                    m_fl_v  = 1'b1;
                    m_fl_pc = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic checkOutput();
        compare("imem_req", {31'b0, bus.imem_req}, {31'b0, (!rst && !branch_taken && !stall_if)});
        compare("imem_addr", bus.imem_addr, m_pc);
        compare("inst_out", inst_out, m_inst);
        compare("pc_out", pc_out, m_pcout);
        compare("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        compare("stall_cycles", stall_cycles, m_cnt);
    endtask

    // Called at a falling edge: drive, check, clock, advance model, return at next falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic b,
                                 input logic [31:0] t);
        rst           = r;
        stall_if      = s;
        flush_id_exec = f;
        branch_taken  = b;
        branch_target = t;
        #1;
        checkOutput();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic normal();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        stall_if      = 1'b0;
        flush_id_exec = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_update();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        compare("lit_reset_valid", {31'b0, inst_valid}, 32'h0);
        compare("lit_reset_inst", inst_out, NOP);
        compare("lit_reset_addr", bus.imem_addr, 32'h0);

        // Reset release: pc 0, 4 stream out two edges after rst falls.
        normal();
        compare("lit_e1_valid", {31'b0, inst_valid}, 32'h0);
        compare("lit_e1_addr", bus.imem_addr, 32'h4);
        normal();
        compare("lit_e2_pc", pc_out, 32'h0);
        compare("lit_e2_inst", inst_out, 32'hA5A5_0000);
        compare("lit_e2_valid", {31'b0, inst_valid}, 32'h1);
        normal();
        compare("lit_e3_pc", pc_out, 32'h4);

        // Three-cycle stall while pc 8 is arriving.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            compare("lit_stall_addr", bus.imem_addr, 32'hC);
            compare("lit_stall_valid", {31'b0, inst_valid}, 32'h0);
        end
        normal();
        compare("lit_release_pc", pc_out, 32'h8);
        compare("lit_release_inst", inst_out, 32'hA5A5_0008);
        normal();
        compare("lit_release2_pc", pc_out, 32'hC);

        // Branch with simultaneous stall.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        compare("lit_br_addr", bus.imem_addr, 32'h100);
        compare("lit_br_bubble1", {31'b0, inst_valid}, 32'h0);
        normal();
        compare("lit_br_bubble2", {31'b0, inst_valid}, 32'h0);
        normal();
        compare("lit_br_target_pc", pc_out, 32'h100);
        compare("lit_br_target_valid", {31'b0, inst_valid}, 32'h1);

        // Flush alone drops one instruction without stalling the PC.
        normal();
        compare("lit_pre_flush_pc", pc_out, 32'h104);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        compare("lit_flush_valid", {31'b0, inst_valid}, 32'h0);
        compare("lit_flush_addr", bus.imem_addr, 32'h110);
        normal();
        compare("lit_post_flush_pc", pc_out, 32'h10C);

        // Address wrap.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        normal();
        compare("lit_wrap_addr", bus.imem_addr, 32'h0);
        normal();
        compare("lit_wrap_pc", pc_out, 32'hFFFF_FFFC);
        compare("lit_wrap_inst", inst_out, 32'h5A5A_FFFC);

        // Reset in the middle of a stall with the replay buffer occupied.
        normal();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        compare("lit_rst_stall_valid", {31'b0, inst_valid}, 32'h0);
        compare("lit_rst_stall_pc", pc_out, 32'h0);
        compare("lit_rst_stall_inst", inst_out, NOP);
        compare("lit_rst_stall_cnt", stall_cycles, 32'h0);
        compare("lit_rst_stall_addr", bus.imem_addr, 32'h0);
        normal();
        compare("lit_restart_bubble", {31'b0, inst_valid}, 32'h0);
        normal();
        compare("lit_restart_pc", pc_out, 32'h0);
        compare("lit_restart_valid", {31'b0, inst_valid}, 32'h1);

        // Randomized hazards.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, f, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            b = ($urandom_range(0, 99) < 10);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom();
            applyStimulus(r, s, f, b, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
